risc_ctrl_sequencer: RTL and testbench

Multi-cycle control FSM for the 16-bit RISC datapath. Requests an instruction from the fetch stage, decodes the 4-bit opcode, and issues one-hot-timed control strobes for register file, ALU, data memory and PC update, one instruction at a time. Sits between the instruction fetch/datapath unit and the register file/ALU/data memory. Provides run/halt control to the top level.

---
 rtl/risc_ctrl_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_risc_ctrl_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_ctrl_sequencer.sv
// rtl/risc_ctrl_sequencer.sv - multi-cycle control FSM for the 16-bit RISC datapath
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module risc_ctrl_sequencer #(
  parameter int MEM_WAIT_MAX     = 15,
  parameter int RESET_STATE_IDLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        fetch_ack,
  input  logic [15:0] instr,
  input  logic        zero_flag,
  input  logic        mem_ack,
  output logic        fetch_req,
  output logic        ir_load,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        halted,
  output logic        bus_err,
  output logic [2:0]  state,
  output logic [15:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam state_t     RESET_STATE = (RESET_STATE_IDLE != 0) ? S_IDLE : S_FETCH;
  localparam logic [3:0] WAIT_LAST   = 4'(MEM_WAIT_MAX - 1);

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [3:0]  opc_q, opc_d;
  logic [3:0]  wait_q, wait_d;
  logic        bus_err_q, bus_err_d;
  logic [3:0]  alu_idx;
  logic        unused_instr_bits;

  assign alu_idx           = opc_q - 4'd2;
  assign unused_instr_bits = ^instr[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      opc_q     <= 4'h0;
      wait_q    <= 4'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    wait_d      = 4'h0;
    bus_err_d   = bus_err_q;
    fetch_req   = 1'b0;
    ir_load     = 1'b0;
    alu_op      = 3'b000;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          // Capture while instr is known valid; DECODE then works from opc_q.
          opc_d   = instr[15:12];
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        if (opc_q == OP_LD || opc_q == OP_ST) begin
          alu_src_imm = 1'b1;
          state_d     = S_MEM;
        end else if (opc_q >= 4'h2 && opc_q <= 4'h9) begin
          alu_op  = alu_idx[2:0];
          state_d = S_WB;
        end else if (opc_q == OP_BEQ) begin
          alu_op    = 3'b001;
          pc_branch = zero_flag;
        end else if (opc_q == OP_BNE) begin
          alu_op    = 3'b001;
          pc_branch = ~zero_flag;
        end else if (opc_q == OP_JMP) begin
          pc_branch = 1'b1;
        end else if (opc_q == OP_HALT) begin
          state_d = S_HALT;
        end
      end

      S_MEM: begin
        mem_read  = (opc_q == OP_LD);
        mem_write = (opc_q == OP_ST);
        wait_d    = wait_q + 4'd1;
        // An ack on the final allowed cycle still completes the access.
        if (mem_ack) begin
          wait_d  = 4'h0;
          state_d = (opc_q == OP_ST) ? S_FETCH : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          wait_d    = 4'h0;
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opc_q == OP_LD);
        state_d    = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus_err = bus_err_q;
  assign state   = state_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic        retire;
  logic [15:0] retire_cnt_q, retire_cnt_d;

  // Timed-out memory ops leave MEM for HALT and so never count.
  assign retire = (state_q == S_EXEC && (state_d == S_FETCH || state_d == S_HALT)) ||
                  (state_q == S_MEM  && state_d == S_FETCH) ||
                  (state_q == S_WB);

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) retire_cnt_d = retire_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= 16'h0000;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_risc_ctrl_sequencer.sv
// tb/tb_risc_ctrl_sequencer.sv - self-checking bench for risc_ctrl_sequencer
// Instruction-level reference model; retire_cnt expectation follows CTRL_RETIRE_CNT_EN.
module tb_risc_ctrl_sequencer;

  localparam int MEM_WAIT_MAX = 15;
  localparam int R_FETCH = 0, R_MEM = 1, R_WB = 2, R_HALT = 3;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n, start, fetch_ack, zero_flag, mem_ack;
  logic [15:0] instr;
  logic        fetch_req, ir_load, alu_src_imm, reg_write, mem_to_reg;
  logic        mem_read, mem_write, pc_inc, pc_branch, halted, bus_err;
  logic [2:0]  alu_op, state;
  logic [15:0] retire_cnt;

  risc_ctrl_sequencer #(.MEM_WAIT_MAX(MEM_WAIT_MAX), .RESET_STATE_IDLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fetch_ack(fetch_ack), .instr(instr),
    .zero_flag(zero_flag), .mem_ack(mem_ack), .fetch_req(fetch_req), .ir_load(ir_load),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .pc_inc(pc_inc), .pc_branch(pc_branch), .halted(halted), .bus_err(bus_err),
    .state(state), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic fr, il; logic [2:0] ao; logic imm, rw, m2r, mr, mw, pi, pb, h, be; logic [2:0] st;
  } obs_t;

  typedef struct {
    logic [3:0] opc; logic zf; int fwait; int mlat; logic [2:0] e_alu; logic e_br; int route;
  } vec_t;

  obs_t obs;
  assign obs = {fetch_req, ir_load, alu_op, alu_src_imm, reg_write, mem_to_reg,
                mem_read, mem_write, pc_inc, pc_branch, halted, bus_err, state};

  int   n_cmp = 0, n_bad = 0;
  int   model_ret = 0;
  logic model_be = 1'b0;
  vec_t tbl [16];

  function automatic obs_t base(input logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    e.h  = (st == ST_HALT);
    e.be = model_be;
    return e;
  endfunction

  function automatic void classify(input logic [3:0] opc, input logic zf,
                                   output logic [2:0] alu, output logic br, output int route);
    int o = int'(opc);
    alu = 3'd0; br = 1'b0; route = R_FETCH;
    if (o <= 1)        route = R_MEM;
    else if (o <= 9) begin alu = 3'(o - 2); route = R_WB; end
    else if (o == 11) begin alu = 3'd1; br = zf; end
    else if (o == 12) begin alu = 3'd1; br = ~zf; end
    else if (o == 13) br = 1'b1;
    else if (o == 15) route = R_HALT;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input obs_t e);
    #1;
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, obs, e, $time);
    end
  endtask

  task automatic chk_ret(input string name);
    logic [15:0] want;
`ifdef CTRL_RETIRE_CNT_EN
    want = model_ret[15:0];
`else
    want = 16'h0000;
`endif
    n_cmp++;
    if (retire_cnt !== want) begin
      n_bad++;
      $display("FAIL %s: retire_cnt got %0d want %0d", name, retire_cnt, want);
    end
  endtask

  task automatic resume();
    obs_t e;
    start = 1'b0; e = base(ST_HALT); chk("halt_hold", e); tick();
    start = 1'b1; chk("halt_start", e); tick();
    start = 1'b0; e = base(ST_FETCH); e.fr = 1'b1; chk("resume_fetch", e);
  endtask

  // Expects the DUT to be in FETCH on entry; leaves it in FETCH on exit.
  task automatic run_instr(input logic [3:0] opc, input logic zf, input int fwait,
                           input int mlat, input logic [2:0] e_alu, input logic e_br,
                           input int route);
    obs_t e;
    bit   retired = 0, halted_now = 0, acked = 0;
    for (int i = 0; i < fwait; i++) begin
      fetch_ack = 1'b0; instr = 16'($urandom);
      e = base(ST_FETCH); e.fr = 1'b1; chk("fetch_wait", e); tick();
    end
    fetch_ack = 1'b1; instr = {opc, 12'($urandom)};
    e = base(ST_FETCH); e.fr = 1'b1; e.il = 1'b1; e.pi = 1'b1; chk("fetch_ack", e); tick();
    fetch_ack = 1'b0;
    e = base(ST_DECODE); chk("decode", e); tick();
    instr = 16'($urandom); zero_flag = zf;
    e = base(ST_EXEC); e.ao = e_alu; e.imm = (route == R_MEM); e.pb = e_br;
    chk("exec", e); tick();
    zero_flag = 1'($urandom);
    if (route == R_MEM) begin
      for (int c = 1; c <= MEM_WAIT_MAX; c++) begin
        mem_ack = (c == mlat);
        e = base(ST_MEM); e.mr = (opc == 4'h0); e.mw = (opc == 4'h1); chk("mem", e);
        tick();
        mem_ack = 1'b0;
        if (c == mlat) begin acked = 1; break; end
      end
      if (!acked) begin model_be = 1'b1; halted_now = 1; end
      else if (opc == 4'h0) begin
        e = base(ST_WB); e.rw = 1'b1; e.m2r = 1'b1; chk("wb_ld", e); tick();
        retired = 1;
      end else retired = 1;
    end else if (route == R_WB) begin
      e = base(ST_WB); e.rw = 1'b1; chk("wb_alu", e); tick();
      retired = 1;
    end else begin
      retired = 1;
      halted_now = (route == R_HALT);
    end
    if (retired) model_ret++;
    chk_ret("retire");
    if (halted_now) resume();
  endtask

  initial begin
    obs_t       e;
    logic [3:0] opc;
    logic       zf, br;
    logic [2:0] alu;
    int         route, mlat;

    tbl[0]  = '{4'h2, 1'b0, 0, 0,  3'd0, 1'b0, R_WB};
    tbl[1]  = '{4'h0, 1'b0, 0, 3,  3'd0, 1'b0, R_MEM};
    tbl[2]  = '{4'hB, 1'b1, 0, 0,  3'd1, 1'b1, R_FETCH};
    tbl[3]  = '{4'hC, 1'b1, 0, 0,  3'd1, 1'b0, R_FETCH};
    tbl[4]  = '{4'hB, 1'b0, 1, 0,  3'd1, 1'b0, R_FETCH};
    tbl[5]  = '{4'hC, 1'b0, 0, 0,  3'd1, 1'b1, R_FETCH};
    tbl[6]  = '{4'h3, 1'b0, 2, 0,  3'd1, 1'b0, R_WB};
    tbl[7]  = '{4'h9, 1'b1, 0, 0,  3'd7, 1'b0, R_WB};
    tbl[8]  = '{4'h8, 1'b0, 0, 0,  3'd6, 1'b0, R_WB};
    tbl[9]  = '{4'hD, 1'b0, 0, 0,  3'd0, 1'b1, R_FETCH};
    tbl[10] = '{4'hA, 1'b1, 0, 0,  3'd0, 1'b0, R_FETCH};
    tbl[11] = '{4'hE, 1'b0, 3, 0,  3'd0, 1'b0, R_FETCH};
    tbl[12] = '{4'h1, 1'b0, 0, 1,  3'd0, 1'b0, R_MEM};
    tbl[13] = '{4'h0, 1'b0, 0, 15, 3'd0, 1'b0, R_MEM};
    tbl[14] = '{4'h1, 1'b0, 0, 0,  3'd0, 1'b0, R_MEM};
    tbl[15] = '{4'hF, 1'b0, 0, 0,  3'd0, 1'b0, R_HALT};

    rst_n = 1'b0; start = 1'b0; fetch_ack = 1'b0; zero_flag = 1'b0; mem_ack = 1'b0;
    instr = 16'h0000;
    #12;
    chk("reset", base(ST_IDLE));
    chk_ret("reset_retire");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("idle", base(ST_IDLE)); tick();
    start = 1'b1; chk("idle_start", base(ST_IDLE)); tick();
    start = 1'b0;

    for (int i = 0; i < 16; i++)
      run_instr(tbl[i].opc, tbl[i].zf, tbl[i].fwait, tbl[i].mlat,
                tbl[i].e_alu, tbl[i].e_br, tbl[i].route);

    for (int i = 0; i < 150; i++) begin
      opc  = 4'($urandom_range(0, 15));
      zf   = 1'($urandom);
      mlat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      classify(opc, zf, alu, br, route);
      run_instr(opc, zf, int'($urandom_range(0, 3)), mlat, alu, br, route);
    end

    // Abandon a load mid-access with an asynchronous reset.
    fetch_ack = 1'b1; instr = 16'h0123;
    e = base(ST_FETCH); e.fr = 1'b1; e.il = 1'b1; e.pi = 1'b1; chk("rst_fetch", e); tick();
    fetch_ack = 1'b0; chk("rst_decode", base(ST_DECODE)); tick();
    e = base(ST_EXEC); e.imm = 1'b1; chk("rst_exec", e); tick();
    e = base(ST_MEM); e.mr = 1'b1; chk("rst_mem", e);
    #2;
    rst_n = 1'b0;
    model_be = 1'b0; model_ret = 0;
    chk("reset_mid_mem", '0);
    chk_ret("reset_mid_mem_retire");
    tick();
    rst_n = 1'b1;
    chk("after_reset_idle", base(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
